// File: rtl/frame_cfg_pkg.sv
// Shared constants, region encoding and derived byte-map addresses for the frame
// configuration register file.
package frame_cfg_pkg;

  localparam int unsigned CTRL_COMMIT = 0;
  localparam int unsigned CTRL_NOW    = 1;

  typedef enum logic [2:0] {
    RegDel,
    RegDur,
    RegRes,
    RegThhv,
    RegCtrl,
    RegStatus,
    RegNone
  } region_e;

  function automatic int unsigned res_base(int unsigned n_ch, int unsigned tw);
    return n_ch * 2 * (tw / 8);
  endfunction

  function automatic int unsigned thhv_addr(int unsigned n_ch, int unsigned tw);
    return res_base(n_ch, tw) + n_ch;
  endfunction

  function automatic int unsigned ctrl_addr(int unsigned n_ch, int unsigned tw);
    return thhv_addr(n_ch, tw) + 1;
  endfunction

  function automatic int unsigned status_addr(int unsigned n_ch, int unsigned tw);
    return ctrl_addr(n_ch, tw) + 1;
  endfunction

endpackage

// File: rtl/cfg_addr_decode.sv
// Combinational byte-address decoder shared by the write and read paths.
// byte_idx 0 is the most significant byte of a delay/duration word.
module cfg_addr_decode
  import frame_cfg_pkg::*;
#(
  parameter int unsigned N_CH = 8,
  parameter int unsigned TW   = 32,
  parameter int unsigned AW   = 8
) (
  input  logic [AW-1:0] addr,
  output region_e       region,
  output logic [3:0]    ch,
  output logic [1:0]    byte_idx,
  output logic          is_ctrl,
  output logic          is_status,
  output logic          invalid
);

  localparam int unsigned B        = TW / 8;
  localparam int unsigned CB       = 2 * B;
  localparam int unsigned ResBase  = res_base(N_CH, TW);
  localparam int unsigned ThhvAddr = thhv_addr(N_CH, TW);
  localparam int unsigned CtrlAddr = ctrl_addr(N_CH, TW);
  localparam int unsigned StatAddr = status_addr(N_CH, TW);

  int unsigned a;
  int unsigned off;

  always_comb begin
    a         = 32'(addr);
    off       = a % CB;
    region    = RegNone;
    ch        = '0;
    byte_idx  = '0;
    is_ctrl   = 1'b0;
    is_status = 1'b0;
    invalid   = 1'b0;
    if (a < ResBase) begin
      ch = 4'(a / CB);
      if (off < B) begin
        region   = RegDel;
        byte_idx = 2'(off);
      end else begin
        region   = RegDur;
        byte_idx = 2'(off - B);
      end
    end else if (a < ThhvAddr) begin
      region = RegRes;
      ch     = 4'(a - ResBase);
    end else if (a == ThhvAddr) begin
      region = RegThhv;
    end else if (a == CtrlAddr) begin
      region  = RegCtrl;
      is_ctrl = 1'b1;
    end else if (a == StatAddr) begin
      region    = RegStatus;
      is_status = 1'b1;
    end else begin
      invalid = 1'b1;
    end
  end

endmodule

// File: rtl/frame_cfg_regs.sv
// Double-buffered sequencer configuration: byte writes land in a shadow bank that is
// copied to the active bank on a frame boundary after a commit request, or immediately.
module frame_cfg_regs
  import frame_cfg_pkg::*;
#(
  parameter int unsigned N_CH = 8,
  parameter int unsigned TW   = 32,
  parameter int unsigned AW   = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [AW-1:0]        addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  output logic                 rd_valid,
  output logic                 err,
  input  logic                 frame_sync,
  output logic [N_CH*TW-1:0]   del,
  output logic [N_CH*TW-1:0]   dur,
  output logic [N_CH*8-1:0]    res_value,
  output logic [7:0]           thhv,
  output logic                 cfg_pending,
  output logic                 cfg_update
);

  localparam int unsigned B        = TW / 8;
  localparam int unsigned StatAddr = status_addr(N_CH, TW);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("frame_cfg_regs: N_CH must be 1..16");
  end
  if ((TW % 8) != 0 || TW < 8 || TW > 32) begin : g_bad_tw
    $error("frame_cfg_regs: TW must be a multiple of 8 in 8..32");
  end
  if (64'(StatAddr) >= (64'd1 << AW)) begin : g_bad_aw
    $error("frame_cfg_regs: AW too narrow for the status address");
  end

  region_e    region;
  logic [3:0] ch;
  logic [1:0] byte_idx;
  logic       is_ctrl, is_status, invalid;

  cfg_addr_decode #(
    .N_CH(N_CH),
    .TW  (TW),
    .AW  (AW)
  ) u_decode (
    .addr     (addr),
    .region   (region),
    .ch       (ch),
    .byte_idx (byte_idx),
    .is_ctrl  (is_ctrl),
    .is_status(is_status),
    .invalid  (invalid)
  );

  logic [N_CH*TW-1:0] sh_del_q, sh_del_d, sh_dur_q, sh_dur_d;
  logic [N_CH*TW-1:0] act_del_q, act_dur_q;
  logic [N_CH*8-1:0]  sh_res_q, sh_res_d, act_res_q;
  logic [7:0]         sh_thhv_q, sh_thhv_d, act_thhv_q;
  logic               pending_q, pending_d;
  logic               ctrl_wr, copy;
  logic [7:0]         rd_byte, rdata_q;
  logic               rd_valid_q, err_q, cfg_update_q;

  // Shadow write path
  always_comb begin
    sh_del_d  = sh_del_q;
    sh_dur_d  = sh_dur_q;
    sh_res_d  = sh_res_q;
    sh_thhv_d = sh_thhv_q;
    if (wr_en) begin
      for (int k = 0; k < N_CH; k++) begin
        for (int j = 0; j < B; j++) begin
          if (ch == 4'(k) && byte_idx == 2'(j)) begin
            if (region == RegDel) sh_del_d[k*TW + (B-1-j)*8 +: 8] = wdata;
            if (region == RegDur) sh_dur_d[k*TW + (B-1-j)*8 +: 8] = wdata;
          end
        end
        if (region == RegRes && ch == 4'(k)) sh_res_d[k*8 +: 8] = wdata;
      end
      if (region == RegThhv) sh_thhv_d = wdata;
    end
  end

  // Read mux always sees the pre-write shadow contents
  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < N_CH; k++) begin
      for (int j = 0; j < B; j++) begin
        if (ch == 4'(k) && byte_idx == 2'(j)) begin
          if (region == RegDel) rd_byte = sh_del_q[k*TW + (B-1-j)*8 +: 8];
          if (region == RegDur) rd_byte = sh_dur_q[k*TW + (B-1-j)*8 +: 8];
        end
      end
      if (region == RegRes && ch == 4'(k)) rd_byte = sh_res_q[k*8 +: 8];
    end
    if (region == RegThhv) rd_byte = sh_thhv_q;
    if (is_status) rd_byte = {7'b0, pending_q};
  end

  always_comb begin
    ctrl_wr   = wr_en & is_ctrl;
    copy      = (ctrl_wr & wdata[CTRL_NOW]) | (pending_q & frame_sync);
    pending_d = pending_q;
    if (copy) begin
      pending_d = 1'b0;
    end else if (ctrl_wr && wdata[CTRL_COMMIT]) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sh_del_q     <= '0;
      sh_dur_q     <= '0;
      sh_res_q     <= '0;
      sh_thhv_q    <= '0;
      act_del_q    <= '0;
      act_dur_q    <= '0;
      act_res_q    <= '0;
      act_thhv_q   <= '0;
      pending_q    <= 1'b0;
      cfg_update_q <= 1'b0;
      rdata_q      <= '0;
      rd_valid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sh_del_q     <= sh_del_d;
      sh_dur_q     <= sh_dur_d;
      sh_res_q     <= sh_res_d;
      sh_thhv_q    <= sh_thhv_d;
      pending_q    <= pending_d;
      cfg_update_q <= copy;
      if (copy) begin
        act_del_q  <= sh_del_q;
        act_dur_q  <= sh_dur_q;
        act_res_q  <= sh_res_q;
        act_thhv_q <= sh_thhv_q;
      end
      rd_valid_q <= rd_en;
      if (rd_en) rdata_q <= invalid ? 8'h00 : rd_byte;
      err_q <= (wr_en | rd_en) & invalid;
    end
  end

  assign del         = act_del_q;
  assign dur         = act_dur_q;
  assign res_value   = act_res_q;
  assign thhv        = act_thhv_q;
  assign cfg_pending = pending_q;
  assign cfg_update  = cfg_update_q;
  assign rdata       = rdata_q;
  assign rd_valid    = rd_valid_q;
  assign err         = err_q;

endmodule

// File: doc/frame_cfg_regs.md
# frame_cfg_regs

Parametrised, clocked configuration register file for the frame/pulse sequencer. It holds per-channel delay and duration words, per-channel reset values and the high-voltage threshold. Host byte writes land in a shadow bank, which is copied atomically to an active bank at a frame boundary or on an explicit immediate commit. Only the active bank drives the sequencer, so a frame never sees a half-written configuration.

## Interface
- N_CH, 8: number of output channels (1..16).
- TW, 32: delay/duration field width in bits; multiple of 8, 8..32.
- AW, 8: address width; must cover STATUS_ADDR (elaboration-time check).
- clk  in  1  system clock; all logic on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- wr_en  in  1  byte write strobe, sampled each edge.
- rd_en  in  1  byte read strobe, sampled each edge.
- addr  in  AW  byte address.
- wdata  in  8  write data.
- rdata  out  8  read data, valid with rd_valid.
- rd_valid  out  1  one-cycle pulse, one per accepted read.
- err  out  1  one-cycle pulse on an access to an unmapped address.
- frame_sync  in  1  frame-boundary strobe from the sequencer.
- del  out  N_CH*TW  active delays; channel k at bits [k*TW +: TW].
- dur  out  N_CH*TW  active durations, same packing.
- res_value  out  N_CH*8  active reset values; channel k at bits [k*8 +: 8].
- thhv  out  8  active threshold.
- cfg_pending  out  1  a commit has been requested and not yet applied.
- cfg_update  out  1  one-cycle pulse in the cycle after an active-bank copy.

## Operation
- Byte map, with B = TW/8:
  - Channel k delay: bytes k*2B .. k*2B+B-1, MSB at the lowest address.
  - Channel k duration: the next B bytes.
  - RES_BASE = N_CH*2B: res_value bytes.
  - THHV_ADDR = RES_BASE+N_CH.
  - CTRL_ADDR = THHV_ADDR+1.
  - STATUS_ADDR = CTRL_ADDR+1.
  - Defaults give del1 at 0..3, dur1 at 4..7, res at 64..71, thhv 72, CTRL 73, STATUS 74.
- Writes to field bytes update the shadow bank only.
- Writes to CTRL:
  - bit0 = 1 sets pending.
  - bit1 = 1 performs an immediate copy and clears pending.
  - Other bits are ignored. CTRL reads as 0x00.
- STATUS is read-only: {7'b0, cfg_pending}. A write to STATUS is ignored and raises no err.
- Reads of field bytes return shadow contents.
- Commit: when pending=1 and frame_sync=1 at an edge, shadow is copied to active and pending clears.
- Out-of-range address (> STATUS_ADDR):
  - A write is dropped and pulses err.
  - A read returns rdata=0x00 with rd_valid=1 and err=1.
- wr_en and rd_en in the same cycle: both are serviced. The read returns the pre-write value.

## Timing
- Reset values: shadow and active banks all zero, so del, dur, res_value and thhv = 0. rdata = 0x00; rd_valid, err, cfg_pending and cfg_update = 0.
- Write latency: shadow updated at the sampling edge.
- Read latency: rdata and rd_valid are registered and appear 1 cycle after rd_en. Back-to-back reads give a rd_valid every cycle.
- Commit latency:
  - A CTRL bit0 write at edge n sets pending at edge n.
  - frame_sync high in the same cycle as that write does not commit, because pending was still 0 when sampled.
  - The first edge m > n with frame_sync=1 copies the bank.
  - del, dur, res_value and thhv change at edge m; cfg_update is high during cycle m+1.
- Immediate commit: active updated at the CTRL write edge; cfg_update follows 1 cycle later.
- A field write coinciding with a copy edge: the copy takes the pre-write shadow value. The new byte stays in shadow and pending is not set automatically.
- CTRL bit0 written while already pending: no effect, no error.
- CTRL with both bits set: immediate copy; pending ends 0.
- clr mid-operation: all state returns to reset values at that edge, and a pending commit is discarded.
- Outputs are glitch-free: active bits change only on a copy edge.

## Structure
- Package frame_cfg_pkg holds:
  - Derived-address functions of (N_CH, TW): RES_BASE, THHV_ADDR, CTRL_ADDR, STATUS_ADDR.
  - CTRL bit indices: CTRL_COMMIT = 0, CTRL_NOW = 1.
- Sub-module cfg_addr_decode (combinational): maps addr to {region, channel, byte index, is_ctrl, is_status, invalid}. It is shared by the write and read paths.
- Top level holds shadow and active storage, the pending flop and the read pipeline register.

## Test plan
- Reset, then write 0x00,0x00,0x01,0x00 at 0..3 and 0x00,0x00,0x00,0x20 at 4..7 -> del[31:0] and dur[31:0] stay 0 and cfg_pending=0. Then write CTRL=0x01 -> cfg_pending=1. Next frame_sync -> del[31:0]=0x00000100, dur[31:0]=0x00000020, cfg_update one pulse, cfg_pending=0.
- Write thhv=0xA5 then CTRL=0x02 -> thhv=0xA5 at the CTRL edge, cfg_update the next cycle, no frame_sync needed.
- Read addr 72 after writing 0x3C -> rdata=0x3C with rd_valid exactly 1 cycle later. Read addr 200 -> rdata=0x00 with err=1 and rd_valid=1.
- Same-cycle write 0x11 and read of addr 9, which held 0x77 -> rdata=0x77; a subsequent read -> 0x11.
- CTRL=0x01 written in a cycle with frame_sync=1 -> no copy. The next frame_sync copies. Field write on the copy edge -> active keeps the old byte.
- clr asserted while cfg_pending=1 -> all outputs 0 at the next edge, and a later frame_sync causes no cfg_update.
